// File: rtl/imem_pipelined.sv
// Instruction memory for an RV32I fetch stage: registered 1- or 2-cycle read with
// stall/flush, fault tagging of bad fetches, and an auto-incrementing program-load port.
module imem_pipelined #(
   parameter int          DEPTH     = 512,
   parameter int          ADDR_W    = 32,
   parameter int          LATENCY   = 1,
   parameter string       INIT_FILE = "",
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     req_valid_i,
   output logic                     req_ready_o,
   input  logic [ADDR_W-1:0]        req_addr_i,
   input  logic                     stall_i,
   input  logic                     flush_i,
   output logic                     rsp_valid_o,
   output logic [31:0]              rsp_instr_o,
   output logic [ADDR_W-1:0]        rsp_pc_o,
   output logic                     rsp_fault_o,
   input  logic                     ld_start_i,
   input  logic [$clog2(DEPTH)-1:0] ld_base_i,
   input  logic                     ld_valid_i,
   input  logic [31:0]              ld_data_i,
   input  logic                     ld_last_i,
   output logic                     ld_busy_o,
   output logic                     ld_err_o
);
   localparam int                AW      = $clog2(DEPTH);
   localparam int                CW      = AW + 1;
   localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
   localparam logic [CW-1:0]     DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0]     CNT_MAX = {CW{1'b1}};

   generate
      if (LATENCY != 1 && LATENCY != 2) begin : g_bad_latency
         $error("imem_pipelined: LATENCY must be 1 or 2");
      end
   endgenerate

   typedef enum logic [0:0] {
      LD_IDLE = 1'b0,
      LD_LOAD = 1'b1
   } ld_state_e;

   logic [31:0]       mem_q [DEPTH];
   ld_state_e         ld_state_q;
   logic [CW-1:0]     ld_cnt_q;
   logic              ld_busy_q;
   logic              ld_err_q;

   logic [ADDR_W-1:0] word_idx_s;
   logic [AW-1:0]     rd_idx_s;
   logic              fault_s;
   logic              accept_s;
   logic              ld_active_s;
   logic [CW-1:0]     wr_ptr_s;
   logic              wr_en_s;

   logic              s1_valid_q;
   logic              s1_fault_q;
   logic [ADDR_W-1:0] s1_pc_q;
   logic [31:0]       s1_instr_q;

   // Fetch decode, handshake and load write-pointer selection
   always_comb begin
      word_idx_s  = {2'b00, req_addr_i[ADDR_W-1:2]};
      rd_idx_s    = req_addr_i[AW+1:2];
      fault_s     = (req_addr_i[1:0] != 2'b00) || (word_idx_s >= DEPTH_A);
      req_ready_o = !stall_i && !flush_i && !ld_busy_q;
      accept_s    = req_valid_i && req_ready_o;
      ld_active_s = ld_start_i || (ld_state_q == LD_LOAD);
      // A start in the same cycle as data writes at the new base, not the stale counter
      wr_ptr_s    = ld_start_i ? {1'b0, ld_base_i} : ld_cnt_q;
      wr_en_s     = !rst_i && ld_active_s && ld_valid_i && (wr_ptr_s < DEPTH_C);
   end

   // Program-load write port; no reset so contents survive rst
   always_ff @(posedge clk_i) begin
      if (wr_en_s) mem_q[wr_ptr_s[AW-1:0]] <= ld_data_i;
   end

   // Load session FSM: counter, busy and sticky overflow flag
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ld_state_q <= LD_IDLE;
         ld_cnt_q   <= {CW{1'b0}};
         ld_busy_q  <= 1'b0;
         ld_err_q   <= 1'b0;
      end else if (ld_active_s) begin
         if (ld_valid_i) begin
            ld_cnt_q <= (wr_ptr_s == CNT_MAX) ? wr_ptr_s : wr_ptr_s + CW'(1);
            ld_err_q <= (ld_err_q && !ld_start_i) || (wr_ptr_s >= DEPTH_C);
         end else begin
            ld_cnt_q <= wr_ptr_s;
            ld_err_q <= ld_err_q && !ld_start_i;
         end
         case ({ld_valid_i, ld_last_i})
            2'b11: begin
               ld_state_q <= LD_IDLE;
               ld_busy_q  <= 1'b0;
            end
            default: begin
               ld_state_q <= LD_LOAD;
               ld_busy_q  <= 1'b1;
            end
         endcase
      end
   end

   // Stage 1: array read, or NOP for faulted / absent requests
   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         s1_valid_q <= 1'b0;
         s1_fault_q <= 1'b0;
         s1_instr_q <= NOP_INSTR;
         if (rst_i) s1_pc_q <= {ADDR_W{1'b0}};
      end else if (!stall_i) begin
         s1_valid_q <= accept_s;
         s1_fault_q <= accept_s && fault_s;
         s1_instr_q <= (accept_s && !fault_s) ? mem_q[rd_idx_s] : NOP_INSTR;
         if (accept_s) s1_pc_q <= req_addr_i;
      end
   end

   generate
      if (LATENCY == 2) begin : g_lat2
         logic              s2_valid_q;
         logic              s2_fault_q;
         logic [ADDR_W-1:0] s2_pc_q;
         logic [31:0]       s2_instr_q;

         // Stage 2: extra output register, same stall/flush rules as stage 1
         always_ff @(posedge clk_i) begin
            if (rst_i || flush_i) begin
               s2_valid_q <= 1'b0;
               s2_fault_q <= 1'b0;
               s2_instr_q <= NOP_INSTR;
               if (rst_i) s2_pc_q <= {ADDR_W{1'b0}};
            end else if (!stall_i) begin
               s2_valid_q <= s1_valid_q;
               s2_fault_q <= s1_fault_q;
               s2_instr_q <= s1_instr_q;
               if (s1_valid_q) s2_pc_q <= s1_pc_q;
            end
         end

         assign rsp_valid_o = s2_valid_q;
         assign rsp_fault_o = s2_fault_q;
         assign rsp_pc_o    = s2_pc_q;
         assign rsp_instr_o = s2_instr_q;
      end else begin : g_lat1
         assign rsp_valid_o = s1_valid_q;
         assign rsp_fault_o = s1_fault_q;
         assign rsp_pc_o    = s1_pc_q;
         assign rsp_instr_o = s1_instr_q;
      end
   endgenerate

   assign ld_busy_o = ld_busy_q;
   assign ld_err_o  = ld_err_q;

endmodule

// File: tb/tb_imem_pipelined.sv
// Scoreboard bench: drives one stimulus stream into LATENCY=1 and LATENCY=2 instances
// and checks each response stream against an independent memory model.
module tb_imem_pipelined;
   localparam int          DEPTH = 16;
   localparam int          AW    = 4;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, req_valid, stall, flush, ld_start, ld_valid, ld_last;
   logic [31:0]   req_addr, ld_data;
   logic [AW-1:0] ld_base;
   logic          rdy1, v1, f1, busy1, err1;
   logic          rdy2, v2, f2, busy2, err2;
   logic [31:0]   i1, pc1, i2, pc2;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        fault;
      logic [31:0] tag;
   } exp_t;

   logic [31:0] model [DEPTH];
   exp_t        q1[$];
   exp_t        q2[$];
   exp_t        last1, last2;
   int          nsc = 0;
   int          edge_kind = 0;   // 0 none, 1 advance, 2 hold, 3 kill

   imem_pipelined #(.DEPTH(DEPTH), .ADDR_W(32), .LATENCY(1)) u_l1 (
      .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(rdy1),
      .req_addr_i(req_addr), .stall_i(stall), .flush_i(flush),
      .rsp_valid_o(v1), .rsp_instr_o(i1), .rsp_pc_o(pc1), .rsp_fault_o(f1),
      .ld_start_i(ld_start), .ld_base_i(ld_base), .ld_valid_i(ld_valid),
      .ld_data_i(ld_data), .ld_last_i(ld_last), .ld_busy_o(busy1), .ld_err_o(err1));

   imem_pipelined #(.DEPTH(DEPTH), .ADDR_W(32), .LATENCY(2)) u_l2 (
      .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(rdy2),
      .req_addr_i(req_addr), .stall_i(stall), .flush_i(flush),
      .rsp_valid_o(v2), .rsp_instr_o(i2), .rsp_pc_o(pc2), .rsp_fault_o(f2),
      .ld_start_i(ld_start), .ld_base_i(ld_base), .ld_valid_i(ld_valid),
      .ld_data_i(ld_data), .ld_last_i(ld_last), .ld_busy_o(busy2), .ld_err_o(err2));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic exp_t exp_of(input logic [31:0] a, input int tag);
      exp_t        e;
      logic [31:0] idx;
      idx     = a >> 2;
      e.pc    = a;
      e.fault = (a[1:0] != 2'b00) || (idx >= 32'd16);
      e.instr = e.fault ? NOP : model[idx[AW-1:0]];
      e.tag   = 32'(tag);
      return e;
   endfunction

   // Push expectations for each request the bench knows is accepted
   always @(posedge clk) begin
      if (rst || flush) begin
         q1.delete();
         q2.delete();
         edge_kind <= 3;
      end else if (stall) begin
         edge_kind <= 2;
      end else begin
         edge_kind <= 1;
         if (req_valid) begin
            q1.push_back(exp_of(req_addr, nsc));
            q2.push_back(exp_of(req_addr, nsc));
         end
         nsc <= nsc + 1;
      end
   end

   task automatic mon(input int d, input int lat, input logic v, input logic [31:0] ins,
                      input logic [31:0] pc, input logic flt);
      exp_t  e;
      int    have;
      string t;
      t    = (d == 1) ? "L1" : "L2";
      have = (d == 1) ? q1.size() : q2.size();
      if (edge_kind == 3) begin
         chk({t, " kill valid"}, {31'd0, v}, 32'd0);
         chk({t, " kill instr"}, ins, NOP);
      end else if (edge_kind == 2) begin
         if (v) begin
            e = (d == 1) ? last1 : last2;
            chk({t, " stall instr"}, ins, e.instr);
            chk({t, " stall pc"}, pc, e.pc);
         end else begin
            chk({t, " stall idle instr"}, ins, NOP);
         end
      end else if (edge_kind == 1) begin
         if (v) begin
            if (have == 0) begin
               checks++;
               errors++;
               $display("FAIL %s unexpected rsp: pc %h, expected none", t, pc);
            end else begin
               if (d == 1) begin
                  e = q1.pop_front();
                  last1 = e;
               end else begin
                  e = q2.pop_front();
                  last2 = e;
               end
               chk({t, " instr"}, ins, e.instr);
               chk({t, " pc"}, pc, e.pc);
               chk({t, " fault"}, {31'd0, flt}, {31'd0, e.fault});
               chk({t, " latency"}, 32'(nsc - int'(e.tag)), 32'(lat));
            end
         end else begin
            chk({t, " idle instr"}, ins, NOP);
            if (have != 0) begin
               e = (d == 1) ? q1[0] : q2[0];
               checks++;
               if (nsc - int'(e.tag) >= lat) begin
                  errors++;
                  $display("FAIL %s missing rsp: got none, expected pc %h", t, e.pc);
               end
            end
         end
      end
   endtask

   // Monitor: compare DUT responses against the scoreboard on the falling edge
   always @(negedge clk) begin
      mon(1, 1, v1, i1, pc1, f1);
      mon(2, 2, v2, i2, pc2, f2);
   end

   task automatic fetch(input logic [31:0] a);
      @(negedge clk);
      req_valid = 1'b1;
      req_addr  = a;
   endtask

   task automatic idle(input int n);
      @(negedge clk);
      req_valid = 1'b0;
      repeat (n - 1) @(negedge clk);
   endtask

   task automatic drained(input string name);
      chk({name, " L1 drained"}, 32'(q1.size()), 32'd0);
      chk({name, " L2 drained"}, 32'(q2.size()), 32'd0);
   endtask

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_addr = 32'd0; stall = 1'b0; flush = 1'b0;
      ld_start = 1'b0; ld_base = 4'd0; ld_valid = 1'b0; ld_data = 32'd0; ld_last = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("reset L1 valid", {31'd0, v1}, 32'd0);
      chk("reset L2 valid", {31'd0, v2}, 32'd0);
      chk("reset L1 instr", i1, NOP);
      chk("reset L2 instr", i2, NOP);
      chk("reset L2 pc", pc2, 32'd0);
      chk("reset L1 fault", {31'd0, f1}, 32'd0);
      chk("reset busy", {30'd0, busy1, busy2}, 32'd0);
      chk("reset err", {30'd0, err1, err2}, 32'd0);
      rst = 1'b0;

      // Program load: start and first word in the same cycle
      @(negedge clk);
      ld_start = 1'b1; ld_base = 4'd0; ld_valid = 1'b1; ld_data = 32'hA000_0000;
      model[0] = 32'hA000_0000;
      for (int i = 1; i < DEPTH; i++) begin
         @(negedge clk);
         ld_start = 1'b0;
         ld_data  = 32'hA000_0000 + 32'(i);
         ld_last  = (i == DEPTH - 1);
         model[i] = 32'hA000_0000 + 32'(i);
         if (i == 1) begin
            #1;
            chk("load busy", {30'd0, busy1, busy2}, 32'd3);
            chk("load ready", {30'd0, rdy1, rdy2}, 32'd0);
         end
      end
      @(negedge clk);
      ld_valid = 1'b0; ld_last = 1'b0;
      #1;
      chk("load done busy", {30'd0, busy1, busy2}, 32'd0);
      chk("load done err", {30'd0, err1, err2}, 32'd0);

      // Back-to-back stream
      fetch(32'h0); fetch(32'h4); fetch(32'h8); fetch(32'hC);
      idle(4);
      drained("stream");

      // Stream with a two-cycle stall
      fetch(32'h0); fetch(32'h4);
      @(negedge clk);
      stall = 1'b1; req_addr = 32'h8;
      #1 chk("stall ready", {31'd0, rdy1}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      stall = 1'b0;
      fetch(32'hC);
      idle(4);
      drained("stall");

      // Flush with two in flight, then refetch
      fetch(32'h0); fetch(32'h4);
      @(negedge clk);
      flush = 1'b1; req_addr = 32'hC;
      #1 chk("flush ready", {31'd0, rdy2}, 32'd0);
      @(negedge clk);
      flush = 1'b0; req_valid = 1'b0;
      fetch(32'h8);
      idle(4);
      drained("flush");

      // Faulting fetches and the last valid word
      fetch(32'h6); fetch(32'h40); fetch(32'h3C);
      idle(4);
      drained("fault");

      // Load past the end of the array
      @(negedge clk);
      ld_start = 1'b1; ld_base = 4'd14;
      @(negedge clk);
      ld_start = 1'b0; ld_valid = 1'b1; ld_data = 32'hB000_0000; model[14] = 32'hB000_0000;
      @(negedge clk);
      ld_data = 32'hB000_0001; model[15] = 32'hB000_0001;
      @(negedge clk);
      ld_data = 32'hB000_0002; ld_last = 1'b1;
      @(negedge clk);
      ld_valid = 1'b0; ld_last = 1'b0;
      #1;
      chk("overflow err", {30'd0, err1, err2}, 32'd3);
      chk("overflow busy", {30'd0, busy1, busy2}, 32'd0);
      fetch(32'h38); fetch(32'h3C);
      idle(4);
      drained("overflow");

      // Reset during a load session and with fetches in flight
      fetch(32'h0);
      @(negedge clk);
      req_addr = 32'h8;
      ld_start = 1'b1; ld_base = 4'd4; ld_valid = 1'b1; ld_data = 32'hC000_0004;
      model[4] = 32'hC000_0004;
      @(negedge clk);
      req_valid = 1'b0; ld_start = 1'b0; ld_valid = 1'b0; rst = 1'b1;
      #1;
      chk("restart err cleared", {30'd0, err1, err2}, 32'd0);
      chk("mid-load busy", {30'd0, busy1, busy2}, 32'd3);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("post-rst busy", {30'd0, busy1, busy2}, 32'd0);
      chk("post-rst valid", {30'd0, v1, v2}, 32'd0);
      chk("post-rst L2 instr", i2, NOP);
      chk("post-rst ready", {30'd0, rdy1, rdy2}, 32'd3);
      fetch(32'h10);
      idle(4);
      drained("reset");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
